// File: rtl/tm_alu_pkg.sv
// rtl/tm_alu_pkg.sv - shared types, width rules and increment policy for the running-average ALU
package tm_alu_pkg;

    // Sequencer states of the running-average ALU.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } tm_state_e;

    // Numerator is a*n + c, held in NUM_W_MULT*W bits; divisor n+1 in W+DEN_W_EXTRA bits.
    localparam int NUM_W_MULT  = 2;
    localparam int DEN_W_EXTRA = 1;

    // How the instance count advances for one transaction.
    typedef enum logic [1:0] {
        INC_ADD  = 2'd0,
        INC_HOLD = 2'd1,
        INC_WRAP = 2'd2
    } inc_kind_e;

    // Saturating-increment policy: add one unless already at the top value,
    // where the count either holds (saturating) or wraps to zero.
    function automatic inc_kind_e sat_inc_kind(input logic at_max, input logic sat_en);
        if (!at_max) begin
            return INC_ADD;
        end else if (sat_en) begin
            return INC_HOLD;
        end else begin
            return INC_WRAP;
        end
    endfunction

endpackage

// File: rtl/tm_div_seq.sv
// rtl/tm_div_seq.sv - start/busy/done restoring divider, one quotient bit per cycle
module tm_div_seq
    import tm_alu_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [NUM_W_MULT*W-1:0]   dividend,
    input  logic [W+DEN_W_EXTRA-1:0]  divisor,
    output logic                      busy,
    output logic                      done,
    output logic [NUM_W_MULT*W-1:0]   quotient
);

    localparam int NUM_W = NUM_W_MULT * W;
    localparam int DEN_W = W + DEN_W_EXTRA;
    localparam int CNT_W = $clog2(NUM_W + 1);

    // The quotient register doubles as the dividend shifter: the dividend MSB
    // leaves on the left while the new quotient bit enters on the right.
    logic [NUM_W-1:0] quo_q, quo_d;
    logic [DEN_W-1:0] rem_q, rem_d;
    logic [DEN_W-1:0] den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DEN_W:0]   rem_shift;

    // One restoring step per cycle while busy; start reloads and clears done.
    always_comb begin
        quo_d     = quo_q;
        rem_d     = rem_q;
        den_d     = den_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = done_q;
        rem_shift = {rem_q, quo_q[NUM_W-1]};
        if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            den_d  = divisor;
            cnt_d  = CNT_W'(NUM_W);
            busy_d = 1'b1;
            done_d = 1'b0;
        end else if (busy_q) begin
            if (rem_shift >= {1'b0, den_q}) begin
                rem_d = DEN_W'(rem_shift - {1'b0, den_q});
                quo_d = {quo_q[NUM_W-2:0], 1'b1};
            end else begin
                rem_d = rem_shift[DEN_W-1:0];
                quo_d = {quo_q[NUM_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    // Divider state register; reset abandons any divide in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            den_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            den_q  <= den_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/tm_alu_seq.sv
// rtl/tm_alu_seq.sv - handshaked running-average / instance-count update for TM statistics
module tm_alu_seq
    import tm_alu_pkg::*;
#(
    parameter int W     = 8,
    parameter int TAG_W = 4,
    parameter int ROUND = 0,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     avg_tx_len,
    input  logic [W-1:0]     inst_exed,
    input  logic [W-1:0]     cur_tx_len,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     avg_tx_len_new,
    output logic [W-1:0]     inst_exed_new,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_sat
);

    localparam int NUM_W = NUM_W_MULT * W;
    localparam int DEN_W = W + DEN_W_EXTRA;

    tm_state_e state_q, state_d;

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     n_q, n_d;
    logic [W-1:0]     c_q, c_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic [W-1:0]     avg_out_q, avg_out_d;
    logic [W-1:0]     cnt_out_q, cnt_out_d;
    logic [TAG_W-1:0] tag_out_q, tag_out_d;
    logic             sat_out_q, sat_out_d;

    logic [NUM_W-1:0] num;
    logic [DEN_W-1:0] den;
    logic [W-1:0]     cnt_new;
    logic             sat_new;
    logic             div_start;
    logic             div_busy;
    logic             div_done;
    logic [NUM_W-1:0] div_quo;

    // Multiplier-adder: numerator a*n + c (plus half the divisor when rounding), divisor n+1.
    always_comb begin
        den = DEN_W'(n_q) + DEN_W'(1);
        num = NUM_W'(a_q) * NUM_W'(n_q) + NUM_W'(c_q);
        if (ROUND != 0) begin
            num = num + NUM_W'(den >> 1);
        end
    end

    // Next instance count from the captured n, with saturate-or-wrap at the top value.
    always_comb begin
        cnt_new = n_q + W'(1);
        sat_new = 1'b0;
        case (sat_inc_kind(&n_q, SAT != 0))
            INC_ADD:  cnt_new = n_q + W'(1);
            INC_HOLD: begin
                cnt_new = n_q;
                sat_new = 1'b1;
            end
            INC_WRAP: cnt_new = '0;
            default:  cnt_new = n_q + W'(1);
        endcase
    end

    tm_div_seq #(
        .W (W)
    ) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (div_start),
        .dividend (num),
        .divisor  (den),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quo)
    );

    // Sequencer: capture operands on accept, launch the divide, publish and hold the result.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        n_d       = n_q;
        c_d       = c_q;
        tag_d     = tag_q;
        avg_out_d = avg_out_q;
        cnt_out_d = cnt_out_q;
        tag_out_d = tag_out_q;
        sat_out_d = sat_out_q;
        div_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = avg_tx_len;
                    n_d     = inst_exed;
                    c_d     = cur_tx_len;
                    tag_d   = in_tag;
                    state_d = ST_MUL;
                end
            end
            ST_MUL: begin
                div_start = 1'b1;
                state_d   = ST_DIV;
            end
            ST_DIV: begin
                if (div_done && !div_busy) begin
                    // Quotient never exceeds max(a, c), so its low W bits are the whole answer.
                    avg_out_d = W'(div_quo);
                    cnt_out_d = cnt_new;
                    tag_out_d = tag_q;
                    sat_out_d = sat_new;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State, operand and result registers; reset drops any in-flight op and clears outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            n_q       <= '0;
            c_q       <= '0;
            tag_q     <= '0;
            avg_out_q <= '0;
            cnt_out_q <= '0;
            tag_out_q <= '0;
            sat_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            n_q       <= n_d;
            c_q       <= c_d;
            tag_q     <= tag_d;
            avg_out_q <= avg_out_d;
            cnt_out_q <= cnt_out_d;
            tag_out_q <= tag_out_d;
            sat_out_q <= sat_out_d;
        end
    end

    // Handshake flags come from the state register only, so out_ready never reaches in_ready.
    assign in_ready       = (state_q == ST_IDLE);
    assign out_valid      = (state_q == ST_DONE);
    assign avg_tx_len_new = avg_out_q;
    assign inst_exed_new  = cnt_out_q;
    assign out_tag        = tag_out_q;
    assign out_sat        = sat_out_q;

endmodule

// File: tb/tb_tm_alu_seq.sv
// tb/tb_tm_alu_seq.sv - self-checking bench for tm_alu_seq across rounding/saturation variants
module tb_tm_alu_seq;

    localparam int W     = 8;
    localparam int TAG_W = 4;
    localparam int ND    = 3;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             out_ready;
    logic [W-1:0]     avg_in;
    logic [W-1:0]     inst_in;
    logic [W-1:0]     cur_in;
    logic [TAG_W-1:0] tag_in;

    logic             in_ready_o  [ND];
    logic             out_valid_o [ND];
    logic             sat_o       [ND];
    logic [W-1:0]     avg_o       [ND];
    logic [W-1:0]     cnt_o       [ND];
    logic [TAG_W-1:0] tag_o       [ND];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    tm_alu_seq #(.W(W), .TAG_W(TAG_W), .ROUND(0), .SAT(1)) dut_r0s1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[0]),
        .avg_tx_len(avg_in), .inst_exed(inst_in), .cur_tx_len(cur_in), .in_tag(tag_in),
        .out_valid(out_valid_o[0]), .out_ready(out_ready), .avg_tx_len_new(avg_o[0]),
        .inst_exed_new(cnt_o[0]), .out_tag(tag_o[0]), .out_sat(sat_o[0])
    );

    tm_alu_seq #(.W(W), .TAG_W(TAG_W), .ROUND(1), .SAT(0)) dut_r1s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[1]),
        .avg_tx_len(avg_in), .inst_exed(inst_in), .cur_tx_len(cur_in), .in_tag(tag_in),
        .out_valid(out_valid_o[1]), .out_ready(out_ready), .avg_tx_len_new(avg_o[1]),
        .inst_exed_new(cnt_o[1]), .out_tag(tag_o[1]), .out_sat(sat_o[1])
    );

    tm_alu_seq #(.W(W), .TAG_W(TAG_W), .ROUND(0), .SAT(0)) dut_r0s0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_o[2]),
        .avg_tx_len(avg_in), .inst_exed(inst_in), .cur_tx_len(cur_in), .in_tag(tag_in),
        .out_valid(out_valid_o[2]), .out_ready(out_ready), .avg_tx_len_new(avg_o[2]),
        .inst_exed_new(cnt_o[2]), .out_tag(tag_o[2]), .out_sat(sat_o[2])
    );

    function automatic int rnd_of(input int i);
        return (i == 1) ? 1 : 0;
    endfunction

    function automatic int sat_of(input int i);
        return (i == 0) ? 1 : 0;
    endfunction

    // Reference: the running-average formula in plain integer arithmetic.
    function automatic int ref_avg(input int a, input int n, input int c, input int rnd);
        int num;
        int d;
        num = a * n + c;
        d   = n + 1;
        if (rnd != 0) num = num + d / 2;
        return num / d;
    endfunction

    function automatic int ref_cnt(input int n, input int sat);
        if (n < (1 << W) - 1) return n + 1;
        return (sat != 0) ? (1 << W) - 1 : 0;
    endfunction

    function automatic int ref_sat(input int n, input int sat);
        return (n == (1 << W) - 1 && sat != 0) ? 1 : 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", name, obs, exp);
        end
    endtask

    task automatic chk_results(input string nm, input int a, input int n, input int c, input int tag);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s d%0d out_valid", nm, i), 32'(out_valid_o[i]), 32'd1);
            chk($sformatf("%s d%0d avg", nm, i), 32'(avg_o[i]), 32'(ref_avg(a, n, c, rnd_of(i))));
            chk($sformatf("%s d%0d cnt", nm, i), 32'(cnt_o[i]), 32'(ref_cnt(n, sat_of(i))));
            chk($sformatf("%s d%0d tag", nm, i), 32'(tag_o[i]), 32'(tag));
            chk($sformatf("%s d%0d sat", nm, i), 32'(sat_o[i]), 32'(ref_sat(n, sat_of(i))));
            chk($sformatf("%s d%0d in_ready busy", nm, i), 32'(in_ready_o[i]), 32'd0);
        end
    endtask

    // One complete transaction: accept, latency, result, optional backpressure, release.
    task automatic do_op(input string nm, input int a, input int n, input int c, input int tag, input int hold);
        int lat;
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s d%0d in_ready idle", nm, i), 32'(in_ready_o[i]), 32'd1);
        end
        avg_in    = a[W-1:0];
        inst_in   = n[W-1:0];
        cur_in    = c[W-1:0];
        tag_in    = tag[TAG_W-1:0];
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        avg_in   = W'($urandom);
        inst_in  = W'($urandom);
        cur_in   = W'($urandom);
        tag_in   = TAG_W'($urandom);
        lat = 0;
        while (!out_valid_o[0] && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk($sformatf("%s latency", nm), 32'(lat), 32'(2 * W + 2));
        chk_results(nm, a, n, c, tag);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk_results($sformatf("%s hold%0d", nm, h), a, n, c, tag);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("%s d%0d out_valid after hs", nm, i), 32'(out_valid_o[i]), 32'd0);
            chk($sformatf("%s d%0d in_ready after hs", nm, i), 32'(in_ready_o[i]), 32'd1);
        end
    endtask

    initial begin
        bit saw_valid;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        avg_in    = '0;
        inst_in   = '0;
        cur_in    = '0;
        tag_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("reset d%0d out_valid", i), 32'(out_valid_o[i]), 32'd0);
            chk($sformatf("reset d%0d in_ready", i), 32'(in_ready_o[i]), 32'd1);
            chk($sformatf("reset d%0d avg", i), 32'(avg_o[i]), 32'd0);
            chk($sformatf("reset d%0d cnt", i), 32'(cnt_o[i]), 32'd0);
            chk($sformatf("reset d%0d tag", i), 32'(tag_o[i]), 32'd0);
            chk($sformatf("reset d%0d sat", i), 32'(sat_o[i]), 32'd0);
        end
        reset = 1'b0;

        do_op("basic", 10, 3, 30, 5, 0);
        do_op("round", 10, 2, 12, 6, 0);
        do_op("first", 77, 0, 40, 7, 0);
        do_op("satur", 200, 255, 100, 8, 0);
        do_op("zeros", 0, 0, 0, 9, 0);
        do_op("maxes", 255, 254, 255, 15, 0);
        do_op("bkpres", 123, 45, 67, 10, 10);

        // Reset in the middle of a divide, with in_valid high during reset.
        @(negedge clk);
        avg_in   = 8'd50;
        inst_in  = 8'd7;
        cur_in   = 8'd9;
        tag_in   = 4'd3;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < ND; i++) begin
            chk($sformatf("midrst d%0d in_ready", i), 32'(in_ready_o[i]), 32'd1);
            chk($sformatf("midrst d%0d out_valid", i), 32'(out_valid_o[i]), 32'd0);
            chk($sformatf("midrst d%0d avg", i), 32'(avg_o[i]), 32'd0);
            chk($sformatf("midrst d%0d cnt", i), 32'(cnt_o[i]), 32'd0);
            chk($sformatf("midrst d%0d tag", i), 32'(tag_o[i]), 32'd0);
            chk($sformatf("midrst d%0d sat", i), 32'(sat_o[i]), 32'd0);
        end
        @(posedge clk);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        saw_valid = 1'b0;
        repeat (24) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid_o[0] || out_valid_o[1] || out_valid_o[2]) saw_valid = 1'b1;
        end
        chk("midrst no stale result", 32'(saw_valid), 32'd0);
        do_op("post_rst", 10, 3, 30, 11, 0);

        // Randomised operands against the reference model.
        for (int k = 0; k < 20; k++) begin
            int a;
            int n;
            int c;
            a = int'($urandom_range(0, 255));
            n = (k % 5 == 0) ? 255 : int'($urandom_range(0, 255));
            c = int'($urandom_range(0, 255));
            do_op($sformatf("rand%0d", k), a, n, c, int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
